// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM (optional MUL decode via MULTICYCLE_CTRL_MUL_EN)
module multicycle_controller (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   pc_write, branch;
  logic   mem_write_raw, ir_write_raw, reg_write_raw;

  // R-type function field to ALU operation; unknown functions fall back to ADD
  function automatic logic [2:0] alu_decode(input logic [5:0] fn);
    case (fn)
      6'b100100: alu_decode = 3'b000;
      6'b100101: alu_decode = 3'b001;
      6'b100000: alu_decode = 3'b010;
      6'b100010: alu_decode = 3'b100;
      6'b101010: alu_decode = 3'b110;
`ifdef MULTICYCLE_CTRL_MUL_EN
      6'b011000: alu_decode = 3'b101;
`endif
      default:   alu_decode = 3'b010;
    endcase
  endfunction

  // State register; reset forces FETCH immediately from any state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state selection; unused codes recover to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; write strobes are masked while reset is held
  always_comb begin
    IorD          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    reg_write_raw = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUControl    = 3'b010;
    PCSrc         = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
        ALUSrcB      = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWR: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = alu_decode(Funct);
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b100;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobe gating and PC enable; PCEn follows Zero combinationally in BRANCH
  always_comb begin
    MemWrite = mem_write_raw & ~RST;
    IRWrite  = ir_write_raw & ~RST;
    RegWrite = reg_write_raw & ~RST;
    PCEn     = (pc_write | (branch & Zero)) & ~RST;
    State    = state_q;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  // expectations published by the stimulus process, checked at negedge
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_state = 4'd0;
  logic [15:0] exp_ctrl  = 16'd0;

  multicycle_controller dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .PCEn(PCEn), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // control word: {pcwrite, branch, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
  //                RegWrite, ALUSrcA, ALUSrcB[1:0], ALUControl[2:0], PCSrc[1:0]}
  function automatic logic [15:0] word(input logic pcw, br, iord, mw, irw, rd, m2r, rw, sa,
                                       input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [1:0] pcs);
    word = {pcw, br, iord, mw, irw, rd, m2r, rw, sa, sb, alu, pcs};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    logic [2:0] r;
    r = 3'b010;
    if (fn == 6'b100100) r = 3'b000;
    if (fn == 6'b100101) r = 3'b001;
    if (fn == 6'b100010) r = 3'b100;
    if (fn == 6'b101010) r = 3'b110;
`ifdef MULTICYCLE_CTRL_MUL_EN
    if (fn == 6'b011000) r = 3'b101;
`endif
    return r;
  endfunction

  // expected control outputs by state, straight from the per-state output table
  function automatic logic [15:0] model_ctrl(input int s, input logic [5:0] fn);
    case (s)
      0:  return word(1,0,0,0,1,0,0,0,0,2'b01,3'b010,2'b00);
      1:  return word(0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00);
      2,
      9:  return word(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00);
      3:  return word(0,0,1,0,0,0,0,0,0,2'b00,3'b010,2'b00);
      4:  return word(0,0,0,0,0,0,1,1,0,2'b00,3'b010,2'b00);
      5:  return word(0,0,1,1,0,0,0,0,0,2'b00,3'b010,2'b00);
      6:  return word(0,0,0,0,0,0,0,0,1,2'b00,funct_alu(fn),2'b00);
      7:  return word(0,0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00);
      8:  return word(0,1,0,0,0,0,0,0,1,2'b00,3'b100,2'b01);
      10: return word(0,0,0,0,0,0,0,1,0,2'b00,3'b010,2'b00);
      11: return word(1,0,0,0,0,0,0,0,0,2'b00,3'b010,2'b10);
      default: return 16'hffff;
    endcase
  endfunction

  // state trace of one instruction, from fetch to the last state before the next fetch
  function automatic void model_seq(input logic [5:0] op, output int seq[$]);
    seq = '{0, 1};
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1};
    endcase
  endfunction

  // the one compare process: DUT against the model on every non-reset cycle
  always @(negedge CLK) begin
    if (exp_valid) begin
      chk("state", int'(State), int'(exp_state));
      chk("ctrl", int'({IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                        ALUSrcB, ALUControl, PCSrc}), int'(exp_ctrl[13:0]));
      chk("pcen", int'(PCEn), int'(exp_ctrl[15] | (exp_ctrl[14] & Zero)));
    end
  end

  // runs one instruction starting at posedge+1 with the DUT in FETCH
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int stop_at);
    int seq[$];
    model_seq(op, seq);
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    foreach (seq[i]) begin
      if (stop_at >= 0 && seq[i] == stop_at) begin
        exp_valid = 1'b0;
        return;
      end
      exp_state = 4'(seq[i]);
      exp_ctrl  = model_ctrl(seq[i], fn);
      exp_valid = 1'b1;
      @(posedge CLK);
      #1;
    end
    exp_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int n;
    // reset: FETCH values with strobes masked
    #2;
    chk("rst_state", int'(State), 0);
    chk("rst_irwrite", int'(IRWrite), 0);
    chk("rst_pcen", int'(PCEn), 0);
    chk("rst_alusrcb", int'(ALUSrcB), 1);
    chk("rst_aluctl", int'(ALUControl), 2);
    release_reset();

    // lw with literal pins at MEMRD and MEMWB
    Opcode = 6'b100011;
    exp_valid = 1'b0;
    n = 0;
    repeat (3) begin @(posedge CLK); #1; n++; end
    chk("lw_memrd_state", int'(State), 3);
    chk("lw_memrd_iord", int'(IorD), 1);
    @(posedge CLK); #1;
    chk("lw_memwb_rw_m2r_rd", int'({RegWrite, MemtoReg, RegDst}), 3'b110);
    @(posedge CLK); #1;
    chk("lw_back_fetch", int'(State), 0);

    // model-checked instruction mix
    run_instr(6'b100011, 6'd0, 1'b0, -1);
    run_instr(6'b101011, 6'd0, 1'b0, -1);
    run_instr(6'b000000, 6'b100010, 1'b0, -1);
    run_instr(6'b000000, 6'b100100, 1'b0, -1);
    run_instr(6'b000000, 6'b100101, 1'b0, -1);
    run_instr(6'b000000, 6'b101010, 1'b0, -1);
    run_instr(6'b000000, 6'b100000, 1'b0, -1);
    run_instr(6'b000000, 6'b111001, 1'b0, -1);
    run_instr(6'b000000, 6'b011000, 1'b0, -1);
    run_instr(6'b001000, 6'd0, 1'b0, -1);
    run_instr(6'b000100, 6'd0, 1'b1, -1);
    run_instr(6'b000100, 6'd0, 1'b0, -1);
    run_instr(6'b000010, 6'd0, 1'b0, -1);
    run_instr(6'b111111, 6'd0, 1'b0, -1);

    // literal pins: sub in EXEC, MUL decode, beq PCEn both ways
    Opcode = 6'b000000; Funct = 6'b100010;
    repeat (2) begin @(posedge CLK); #1; end
    chk("sub_exec", int'({State, ALUControl, ALUSrcA, ALUSrcB}), {4'd6, 3'b100, 1'b1, 2'b00});
    Funct = 6'b011000;
    #1;
`ifdef MULTICYCLE_CTRL_MUL_EN
    chk("mul_aluctl", int'(ALUControl), 5);
`else
    chk("mul_aluctl", int'(ALUControl), 2);
`endif
    repeat (2) begin @(posedge CLK); #1; end
    Opcode = 6'b000100; Zero = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    chk("beq_taken", int'({State, PCEn, PCSrc}), {4'd8, 1'b1, 2'b01});
    Zero = 1'b0;
    #1;
    chk("beq_not_taken", int'(PCEn), 0);
    @(posedge CLK); #1;
    chk("beq_back_fetch", int'(State), 0);

    // sw interrupted by reset while in MEMWR
    run_instr(6'b101011, 6'd0, 1'b0, 5);
    chk("sw_memwr_mw", int'({State, MemWrite}), {4'd5, 1'b1});
    #1;
    RST = 1'b1;
    #1;
    chk("sw_rst_state", int'(State), 0);
    chk("sw_rst_mw", int'(MemWrite), 0);
    chk("sw_rst_pcen", int'(PCEn), 0);
    @(posedge CLK); #1;
    chk("sw_rst_hold", int'({State, PCEn, IRWrite, RegWrite}), 0);
    release_reset();
    run_instr(6'b000010, 6'd0, 1'b0, -1);
    run_instr(6'b001000, 6'd0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
